// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller.
// The forward-select values match the ALU operand mux select bus of the core.
package pipe_hazard_ctrl_pkg;

  // ALU operand source: register file, ALU_MEM latch, or MEM_WB latch.
  typedef enum logic [1:0] {
    FWD_REG     = 2'b00,
    FWD_ALU_MEM = 2'b01,
    FWD_MEM_WB  = 2'b10
  } fwd_sel_e;

  // Width of the optional performance counters.
  localparam int PERF_W = 32;

  // Bits in one shadow slot: {valid, rd, we, is_load}.
  function automatic int haz_slot_w(input int reg_addr_w);
    return reg_addr_w + 3;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decoder <-> hazard controller bundle.
// master: decoder / pipeline side. slave: pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 2
) ();
  logic                  dec_valid;
  logic [REG_ADDR_W-1:0] dec_rs1;
  logic [REG_ADDR_W-1:0] dec_rs2;
  logic [REG_ADDR_W-1:0] dec_rd;
  logic                  dec_we;
  logic                  dec_is_load;
  logic                  br_taken;
  logic                  stall_if;
  logic                  bubble_dec;
  logic                  flush_front;
  logic [SEL_W-1:0]      select1;
  logic [SEL_W-1:0]      select2;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_we, dec_is_load, br_taken,
    input  stall_if, bubble_dec, flush_front, select1, select2
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_we, dec_is_load, br_taken,
    output stall_if, bubble_dec, flush_front, select1, select2
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_slot.sv
// One shadow slot of an in-flight instruction: {valid, rd, we, is_load}.
// i_kill turns the captured entry into a bubble (valid cleared).
module hazard_slot #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_kill,
  input  logic                  i_valid,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic                  i_we,
  input  logic                  i_is_load,
  output logic                  o_valid,
  output logic [REG_ADDR_W-1:0] o_rd,
  output logic                  o_we,
  output logic                  o_is_load
);

  logic                  r_valid;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_we;
  logic                  r_is_load;

  // Capture the upstream entry each edge; a kill inserts a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_rd      <= '0;
      r_we      <= 1'b0;
      r_is_load <= 1'b0;
    end else begin
      r_valid   <= i_valid & ~i_kill;
      r_rd      <= i_rd;
      r_we      <= i_we;
      r_is_load <= i_is_load;
    end
  end

  assign o_valid   = r_valid;
  assign o_rd      = r_rd;
  assign o_we      = r_we;
  assign o_is_load = r_is_load;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core.
// Tracks EX/MEM/WB destinations in shadow slots and produces operand
// forward selects, load-use stalls and branch-redirect flushes.
// Optional feature macro: HAZARD_PERF_EN (adds stall/flush perf counters).
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int SEL_W        = 2,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                clk,
  input  logic                resetIn,
  pipe_hazard_ctrl_if.slave   hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0]   perf_stall_cnt,
  output logic [PERF_W-1:0]   perf_flush_cnt
`endif
);

  localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);

  // EX slot (fed from decode)
  logic                  w_ex_valid;
  logic [REG_ADDR_W-1:0] w_ex_rd;
  logic                  w_ex_we;
  logic                  w_ex_is_load;
  // MEM slot
  logic                  w_mem_valid;
  logic [REG_ADDR_W-1:0] w_mem_rd;
  logic                  w_mem_we;
  logic                  w_mem_is_load;
  // WB slot (is_load kept for symmetry, not needed for forwarding)
  logic                  w_wb_valid;
  logic [REG_ADDR_W-1:0] w_wb_rd;
  logic                  w_wb_we;
  logic                  w_unused_wb_is_load;

  logic [REG_ADDR_W-1:0] r_ex_rs1;
  logic [REG_ADDR_W-1:0] r_ex_rs2;
  logic [FCNT_W-1:0]     r_fcnt;

  logic w_load_use;
  logic w_br;
  logic w_flush;
  logic w_bubble;

  // Forward source for one EX operand; the MEM producer is younger and wins.
  function automatic logic [SEL_W-1:0] fwd_pick(
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  mem_ok,
    input logic [REG_ADDR_W-1:0] mem_rd,
    input logic                  wb_ok,
    input logic [REG_ADDR_W-1:0] wb_rd
  );
    logic [SEL_W-1:0] sel;
    sel = SEL_W'(FWD_REG);
    if (rs != '0) begin
      if (mem_ok && (mem_rd == rs))     sel = SEL_W'(FWD_ALU_MEM);
      else if (wb_ok && (wb_rd == rs))  sel = SEL_W'(FWD_MEM_WB);
    end
    return sel;
  endfunction

  hazard_slot #(.REG_ADDR_W(REG_ADDR_W)) u_slot_ex (
    .clk       (clk),
    .rst       (resetIn),
    .i_kill    (w_bubble),
    .i_valid   (hz.dec_valid),
    .i_rd      (hz.dec_rd),
    .i_we      (hz.dec_we),
    .i_is_load (hz.dec_is_load),
    .o_valid   (w_ex_valid),
    .o_rd      (w_ex_rd),
    .o_we      (w_ex_we),
    .o_is_load (w_ex_is_load)
  );

  hazard_slot #(.REG_ADDR_W(REG_ADDR_W)) u_slot_mem (
    .clk       (clk),
    .rst       (resetIn),
    .i_kill    (1'b0),
    .i_valid   (w_ex_valid),
    .i_rd      (w_ex_rd),
    .i_we      (w_ex_we),
    .i_is_load (w_ex_is_load),
    .o_valid   (w_mem_valid),
    .o_rd      (w_mem_rd),
    .o_we      (w_mem_we),
    .o_is_load (w_mem_is_load)
  );

  hazard_slot #(.REG_ADDR_W(REG_ADDR_W)) u_slot_wb (
    .clk       (clk),
    .rst       (resetIn),
    .i_kill    (1'b0),
    .i_valid   (w_mem_valid),
    .i_rd      (w_mem_rd),
    .i_we      (w_mem_we),
    .i_is_load (w_mem_is_load),
    .o_valid   (w_wb_valid),
    .o_rd      (w_wb_rd),
    .o_we      (w_wb_we),
    .o_is_load (w_unused_wb_is_load)
  );

  // EX source registers follow decode; a killed entry is masked by EX valid.
  always_ff @(posedge clk or posedge resetIn) begin
    if (resetIn) begin
      r_ex_rs1 <= '0;
      r_ex_rs2 <= '0;
    end else begin
      r_ex_rs1 <= hz.dec_rs1;
      r_ex_rs2 <= hz.dec_rs2;
    end
  end

  // Flush hold counter: loaded by a taken branch, counts down to zero and stays.
  always_ff @(posedge clk or posedge resetIn) begin
    if (resetIn) begin
      r_fcnt <= '0;
    end else if (w_br) begin
      r_fcnt <= FCNT_W'(FLUSH_CYCLES - 1);
    end else if (r_fcnt != '0) begin
      r_fcnt <= r_fcnt - 1'b1;
    end
  end

  // Hazard decisions: load-use from decode vs EX, branch honoured only for a live EX.
  always_comb begin
    w_load_use = hz.dec_valid & w_ex_valid & w_ex_we & w_ex_is_load &
                 (w_ex_rd != '0) &
                 ((w_ex_rd == hz.dec_rs1) | (w_ex_rd == hz.dec_rs2));
    w_br       = hz.br_taken & w_ex_valid;
    w_flush    = w_br | (r_fcnt != '0);
    w_bubble   = w_load_use | w_flush;
  end

  // The redirect must reach the PC, so a flush overrides the stall.
  assign hz.stall_if    = w_load_use & ~w_flush;
  assign hz.bubble_dec  = w_bubble;
  assign hz.flush_front = w_flush;

  // Operand selects depend only on registered shadow state.
  assign hz.select1 = fwd_pick(r_ex_rs1, w_mem_valid & w_mem_we & ~w_mem_is_load, w_mem_rd,
                               w_wb_valid & w_wb_we, w_wb_rd);
  assign hz.select2 = fwd_pick(r_ex_rs2, w_mem_valid & w_mem_we & ~w_mem_is_load, w_mem_rd,
                               w_wb_valid & w_wb_we, w_wb_rd);

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] r_perf_stall;
  logic [PERF_W-1:0] r_perf_flush;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Count stall and flush cycles, saturating.
  always_ff @(posedge clk or posedge resetIn) begin
    if (resetIn) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (hz.stall_if) r_perf_stall <= sat_inc(r_perf_stall);
      if (w_flush)     r_perf_flush <= sat_inc(r_perf_flush);
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (FLUSH_CYCLES=2).
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic resetIn;
  int   n_checks = 0;
  int   n_errors = 0;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  pipe_hazard_ctrl_if #(.REG_ADDR_W(5), .SEL_W(2)) bus ();

  pipe_hazard_ctrl #(
    .REG_ADDR_W  (5),
    .SEL_W       (2),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk     (clk),
    .resetIn (resetIn),
    .hz      (bus)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic we, input logic ld);
    bus.dec_valid   = v;
    bus.dec_rs1     = rs1;
    bus.dec_rs2     = rs2;
    bus.dec_rd      = rd;
    bus.dec_we      = we;
    bus.dec_is_load = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  initial begin
    resetIn      = 1'b1;
    bus.br_taken = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #12;
    chk("rst_stall",  {31'd0, bus.stall_if},    32'd0);
    chk("rst_bubble", {31'd0, bus.bubble_dec},  32'd0);
    chk("rst_flush",  {31'd0, bus.flush_front}, 32'd0);
    chk("rst_sel1",   {30'd0, bus.select1},     32'd0);
    chk("rst_sel2",   {30'd0, bus.select2},     32'd0);
    resetIn = 1'b0;
    tick();

    // add x5 ; add x6,x5,x1 back-to-back
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0); tick();
    drive(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0); tick();
    #1;
    chk("b2b_sel1",  {30'd0, bus.select1},  32'd1);
    chk("b2b_sel2",  {30'd0, bus.select2},  32'd0);
    chk("b2b_stall", {31'd0, bus.stall_if}, 32'd0);
    drain();

    // add x5 ; independent ; add x6,x5,x1
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0); tick();
    drive(1'b1, 5'd3, 5'd4, 5'd8, 1'b1, 1'b0); tick();
    drive(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0); tick();
    #1;
    chk("gap_sel1", {30'd0, bus.select1}, 32'd2);
    drain();

    // x5 in MEM and in WB, EX reads x5 on operand 2
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0); tick();
    drive(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0); tick();
    drive(1'b1, 5'd3, 5'd5, 5'd6, 1'b1, 1'b0); tick();
    #1;
    chk("young_sel2", {30'd0, bus.select2}, 32'd1);
    chk("young_sel1", {30'd0, bus.select1}, 32'd0);
    drain();

    // lw x7 in EX while decode reads x7
    drive(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1); tick();
    drive(1'b1, 5'd2, 5'd7, 5'd9, 1'b1, 1'b0);
    #1;
    chk("lu_stall",  {31'd0, bus.stall_if},    32'd1);
    chk("lu_bubble", {31'd0, bus.bubble_dec},  32'd1);
    chk("lu_flush",  {31'd0, bus.flush_front}, 32'd0);
    tick();
    chk("lu_stall_1cyc",  {31'd0, bus.stall_if},   32'd0);
    chk("lu_bubble_1cyc", {31'd0, bus.bubble_dec}, 32'd0);
    tick();
    chk("lu_fwd_sel2", {30'd0, bus.select2}, 32'd2);
    drain();

    // load to x0 never stalls
    drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1); tick();
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
    #1;
    chk("x0_stall",  {31'd0, bus.stall_if},   32'd0);
    chk("x0_bubble", {31'd0, bus.bubble_dec}, 32'd0);
    drain();

    // taken branch, flush held 2 cycles, EX killed twice
    drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd3, 5'd4, 5'd10, 1'b1, 1'b0);
    bus.br_taken = 1'b1;
    #1;
    chk("br_flush0",  {31'd0, bus.flush_front}, 32'd1);
    chk("br_bubble0", {31'd0, bus.bubble_dec},  32'd1);
    chk("br_stall0",  {31'd0, bus.stall_if},    32'd0);
    tick();
    chk("br_flush1",  {31'd0, bus.flush_front}, 32'd1);
    chk("br_bubble1", {31'd0, bus.bubble_dec},  32'd1);
    tick();
    // EX still invalid here, so a held br_taken is ignored
    chk("br_ignored", {31'd0, bus.flush_front}, 32'd0);
    chk("br_bubble2", {31'd0, bus.bubble_dec},  32'd0);
    bus.br_taken = 1'b0;
    tick();
    chk("br_done", {31'd0, bus.flush_front}, 32'd0);
`ifdef HAZARD_PERF_EN
    chk("perf_stall_a", perf_stall_cnt, 32'd1);
    chk("perf_flush_a", perf_flush_cnt, 32'd2);
`endif
    drain();

    // branch and load-use together: branch wins
    drive(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1); tick();
    drive(1'b1, 5'd7, 5'd0, 5'd9, 1'b1, 1'b0);
    bus.br_taken = 1'b1;
    #1;
    chk("both_stall",  {31'd0, bus.stall_if},    32'd0);
    chk("both_flush",  {31'd0, bus.flush_front}, 32'd1);
    chk("both_bubble", {31'd0, bus.bubble_dec},  32'd1);
    tick();
    bus.br_taken = 1'b0;
    #1;
    chk("both_hold", {31'd0, bus.flush_front}, 32'd1);
    tick();
    chk("both_end", {31'd0, bus.flush_front}, 32'd0);
`ifdef HAZARD_PERF_EN
    chk("perf_stall_b", perf_stall_cnt, 32'd1);
    chk("perf_flush_b", perf_flush_cnt, 32'd4);
`endif
    drain();

    // reset while stalled, with an active forward
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0); tick();
    drive(1'b1, 5'd5, 5'd0, 5'd7, 1'b1, 1'b1); tick();
    drive(1'b1, 5'd7, 5'd0, 5'd9, 1'b1, 1'b0);
    #1;
    chk("pre_rst_stall", {31'd0, bus.stall_if}, 32'd1);
    chk("pre_rst_sel1",  {30'd0, bus.select1},  32'd1);
    #1;
    resetIn = 1'b1;
    #1;
    chk("mid_rst_stall",  {31'd0, bus.stall_if},    32'd0);
    chk("mid_rst_bubble", {31'd0, bus.bubble_dec},  32'd0);
    chk("mid_rst_flush",  {31'd0, bus.flush_front}, 32'd0);
    chk("mid_rst_sel1",   {30'd0, bus.select1},     32'd0);
`ifdef HAZARD_PERF_EN
    chk("mid_rst_perf_s", perf_stall_cnt, 32'd0);
    chk("mid_rst_perf_f", perf_flush_cnt, 32'd0);
`endif
    tick();
    resetIn = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
